// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare/select opcodes, FP32 field widths and the
// canonical quiet-NaN constant builder.
package fpu_pkg;

    typedef enum logic [2:0] {
        FCMP_EQ  = 3'b000,
        FCMP_NE  = 3'b001,
        FCMP_LE  = 3'b010,
        FCMP_GE  = 3'b011,
        FCMP_LT  = 3'b100,
        FCMP_GT  = 3'b101,
        FCMP_MIN = 3'b110,
        FCMP_MAX = 3'b111
    } fcmp_op_t;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int NAN_MAX_W  = 128;

    // Sign 0, exponent all ones, mantissa MSB set; callers keep the low W bits.
    function automatic logic [NAN_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
        logic [NAN_MAX_W-1:0] v;
        v = {NAN_MAX_W{1'b0}};
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpu_cmp_pipe_if.sv
// Issue/result handshake bundle of the compare/select pipe; the master
// drives operands and accepts results, the slave is the compare unit.
interface fpu_cmp_pipe_if import fpu_pkg::*; #(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a_data;
    logic [W-1:0]     b_data;
    logic [2:0]       op_data;
    logic [TAG_W-1:0] in_tag;
    logic             c_valid;
    logic             c_ready;
    logic [W-1:0]     c_data;
    logic [TAG_W-1:0] c_tag;
    logic             c_invalid;

    modport master (
        output in_valid, a_data, b_data, op_data, in_tag, c_ready,
        input  in_ready, c_valid, c_data, c_tag, c_invalid
    );

    modport slave (
        input  in_valid, a_data, b_data, op_data, in_tag, c_ready,
        output in_ready, c_valid, c_data, c_tag, c_invalid
    );
endinterface

// File: rtl/fpu_cmp_key.sv
// Maps one FP operand to an unsigned ordering key plus zero-class and NaN
// flags. NaN detection exists only when FPU_CMP_NAN_EN is defined.
module fpu_cmp_key #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] val,
    output logic [W-1:0] key,
    output logic         is_zero,
    output logic         is_nan
);
    logic [EXP_W-1:0] exp_s;

    assign exp_s   = val[W-2:MAN_W];
    assign is_zero = (exp_s == {EXP_W{1'b0}});

    // Negative values invert fully so larger magnitudes sort lower.
    always_comb begin
        key = {W{1'b0}};
        if (val[W-1]) begin
            key = ~val;
        end else begin
            key = {1'b1, val[W-2:0]};
        end
    end

`ifdef FPU_CMP_NAN_EN
    assign is_nan = (exp_s == {EXP_W{1'b1}}) && (val[MAN_W-1:0] != {MAN_W{1'b0}});
`else
    assign is_nan = 1'b0;
`endif

endmodule

// File: rtl/fpu_cmp_pipe.sv
// Two-stage elastic FP compare/select pipe (EQ/NE/LE/GE/LT/GT, MIN/MAX).
// Optional NaN handling is compiled in with FPU_CMP_NAN_EN.
module fpu_cmp_pipe import fpu_pkg::*; #(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int TAG_W = 5
) (
    input logic           aclk,
    input logic           aresetn,
    fpu_cmp_pipe_if.slave io
);
    localparam int           W        = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] ZERO_KEY = {1'b1, {(W-1){1'b0}}};
`ifdef FPU_CMP_NAN_EN
    localparam logic [NAN_MAX_W-1:0] CNAN_WIDE = canonical_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]         CNAN      = CNAN_WIDE[W-1:0];
`endif

    logic [W-1:0] ka_s, kb_s;
    logic         za_s, zb_s, na_s, nb_s;
    logic         s2_load_s, s1_load_s;

    logic             s1_valid_r;
    fcmp_op_t         s1_op_r;
    logic [W-1:0]     s1_a_r, s1_b_r, s1_ka_r, s1_kb_r;
    logic             s1_za_r, s1_zb_r, s1_na_r, s1_nb_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             c_valid_r;
    logic [W-1:0]     c_data_r;
    logic [TAG_W-1:0] c_tag_r;
    logic             c_invalid_r;

    logic [W-1:0] ka_eff_s, kb_eff_s, res_data_s;
    logic         eq_s, lt_s, gt_s, res_bit_s, nan_any_s;

    fpu_cmp_key #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_key_a (
        .val(io.a_data), .key(ka_s), .is_zero(za_s), .is_nan(na_s)
    );
    fpu_cmp_key #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_key_b (
        .val(io.b_data), .key(kb_s), .is_zero(zb_s), .is_nan(nb_s)
    );

    assign s2_load_s   = !c_valid_r || io.c_ready;
    assign s1_load_s   = !s1_valid_r || s2_load_s;
    assign io.in_ready = s1_load_s;

    // Stage 1: capture keys, flags and operands only on a handshake.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= FCMP_EQ;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
            s1_ka_r    <= {W{1'b0}};
            s1_kb_r    <= {W{1'b0}};
            s1_za_r    <= 1'b0;
            s1_zb_r    <= 1'b0;
            s1_na_r    <= 1'b0;
            s1_nb_r    <= 1'b0;
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= io.in_valid;
            if (io.in_valid) begin
                s1_op_r  <= fcmp_op_t'(io.op_data);
                s1_a_r   <= io.a_data;
                s1_b_r   <= io.b_data;
                s1_ka_r  <= ka_s;
                s1_kb_r  <= kb_s;
                s1_za_r  <= za_s;
                s1_zb_r  <= zb_s;
                s1_na_r  <= na_s;
                s1_nb_r  <= nb_s;
                s1_tag_r <= io.in_tag;
            end
        end
    end

    // Result resolution; zero-class operands collapse onto the +0 key here.
    always_comb begin
        ka_eff_s   = s1_za_r ? ZERO_KEY : s1_ka_r;
        kb_eff_s   = s1_zb_r ? ZERO_KEY : s1_kb_r;
        eq_s       = (ka_eff_s == kb_eff_s);
        lt_s       = (ka_eff_s <  kb_eff_s);
        gt_s       = (ka_eff_s >  kb_eff_s);
        nan_any_s  = s1_na_r || s1_nb_r;
        res_bit_s  = 1'b0;
        res_data_s = {W{1'b0}};
        case (s1_op_r)
            FCMP_EQ:  res_bit_s = eq_s;
            FCMP_NE:  res_bit_s = !eq_s;
            FCMP_LE:  res_bit_s = !gt_s;
            FCMP_GE:  res_bit_s = !lt_s;
            FCMP_LT:  res_bit_s = lt_s;
            FCMP_GT:  res_bit_s = gt_s;
            default:  res_bit_s = 1'b0;
        endcase
`ifdef FPU_CMP_NAN_EN
        if (nan_any_s) begin
            res_bit_s = (s1_op_r == FCMP_NE);
        end else begin
            res_bit_s = res_bit_s;
        end
`endif
        case (s1_op_r)
            FCMP_MIN: res_data_s = gt_s ? s1_b_r : s1_a_r;
            FCMP_MAX: res_data_s = lt_s ? s1_b_r : s1_a_r;
            default:  res_data_s = {{(W-1){1'b0}}, res_bit_s};
        endcase
`ifdef FPU_CMP_NAN_EN
        // MIN/MAX prefer the non-NaN operand; two NaNs yield the canonical NaN.
        if (nan_any_s && (s1_op_r == FCMP_MIN || s1_op_r == FCMP_MAX)) begin
            if (s1_na_r && s1_nb_r) begin
                res_data_s = CNAN;
            end else if (s1_na_r) begin
                res_data_s = s1_b_r;
            end else begin
                res_data_s = s1_a_r;
            end
        end else begin
            res_data_s = res_data_s;
        end
`endif
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            c_valid_r   <= 1'b0;
            c_data_r    <= {W{1'b0}};
            c_tag_r     <= {TAG_W{1'b0}};
            c_invalid_r <= 1'b0;
        end else if (s2_load_s) begin
            c_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                c_data_r    <= res_data_s;
                c_tag_r     <= s1_tag_r;
                c_invalid_r <= nan_any_s;
            end
        end
    end

    assign io.c_valid   = c_valid_r;
    assign io.c_data    = c_data_r;
    assign io.c_tag     = c_tag_r;
    assign io.c_invalid = c_invalid_r;

endmodule

// File: doc/fpu_cmp_pipe.md
# fpu_cmp_pipe

Parametrised, fully pipelined floating-point compare/select unit for the core's FPU cluster. It accepts one operand pair per cycle under a valid/ready handshake, resolves EQ/NE/LE/GE/LT/GT as a 1-bit result and MIN/MAX as a selected operand, and returns results two cycles later in issue order with a sideband tag. It replaces the two-cycle, non-pipelined compare path and removes its idle cycle between operations.

## Interface
Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width; operand width W = 1 + EXP_W + MAN_W.
- TAG_W, 5, width of the sideband tag carried with each operation (e.g. destination register).

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  reset; asynchronous, active-high (asserted = 1).
- in_valid  in  1  operand pair and op present.
- in_ready  out  1  unit accepts this cycle.
- a_data  in  W  operand A.
- b_data  in  W  operand B.
- op_data  in  3  000 EQ, 001 NE, 010 LE, 011 GE, 100 LT, 101 GT, 110 MIN, 111 MAX.
- in_tag  in  TAG_W  sideband, returned unchanged.
- c_valid  out  1  result present.
- c_ready  in  1  consumer accepts result.
- c_data  out  W  compares: bit 0 = result, bits W-1:1 = 0; MIN/MAX: selected operand.
- c_tag  out  TAG_W  tag of the operation in c_data.
- c_invalid  out  1  a NaN operand was involved (see Configuration).

## Operation
- Zero class: exponent field all zero, including subnormals (flush-to-zero). Any two zero-class operands, regardless of sign, compare equal.
- Ordering key per operand: if sign = 1, invert all bits; otherwise invert the sign bit only. Compare keys unsigned. Zero-class operands map to the key of +0 before comparison.
- Results: EQ = (ka == kb); NE = !EQ; LE = ka <= kb; GE = ka >= kb; LT = ka < kb; GT = ka > kb.
- MIN returns a_data if ka <= kb, otherwise b_data. MAX returns a_data if ka >= kb, otherwise b_data. The original bit pattern is returned, so a tie between +0 and -0 returns A.
- Stage 1 registers the keys, zero/NaN flags, op, operands, and tag. Stage 2 registers the final c_data, c_tag, and c_invalid.
- Elastic pipeline, with one valid bit per stage:
  - Stage 2 loads when !s2_valid || c_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || stage 2 loads.
- No combinational path from c_ready to c_data. The path from c_ready to in_ready is allowed.
- Reset values: in_ready = 1 after reset is released; c_valid = 0, c_data = 0, c_tag = 0, c_invalid = 0; both stage valid bits are 0.

## Timing
- Latency: an operation accepted at edge N (in_valid && in_ready) presents c_valid at edge N+2, provided c_ready was not blocking.
- Throughput: 1 operation per cycle with c_ready held at 1.
- Backpressure: while c_valid && !c_ready, c_data, c_tag, and c_invalid hold stable. Up to 2 operations are buffered, after which in_ready = 0.
- Simultaneous accept and drain on a full pipe: the output drains, stage 1 advances, and the new input is taken in the same cycle. No bubble.
- Ordering: strictly in order. No operation is dropped or duplicated.
- Reset mid-operation: all in-flight operations are discarded immediately and outputs return to their reset values without waiting for a clock edge.
- in_valid and operands may change freely while in_ready = 0. Nothing is captured until handshake.

## Configuration
- FPU_CMP_NAN_EN defined: NaN = exponent all ones and mantissa nonzero.
  - If either operand is NaN: EQ, LE, GE, LT, GT = 0; NE = 1.
  - MIN/MAX return the non-NaN operand. If both operands are NaN, they return the canonical NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0).
  - c_invalid = 1 for that result.
- FPU_CMP_NAN_EN undefined: no NaN detection. NaN patterns are ordered by key like any other value, and c_invalid is tied to 0.

## Structure
- Shared package fpu_pkg holds:
  - the fcmp_op_t enum (3-bit codes above);
  - default EXP_W/MAN_W constants for FP32;
  - the canonical-NaN constant function.
- One sub-module, fpu_cmp_key, instantiated twice. It is combinational and parametrised by EXP_W/MAN_W. It outputs the key, the zero flag, and the NaN flag.
- The top level holds the two pipeline stages and the handshake logic.

## Test plan
- LT, A=0xBF800000 (-1.0), B=0x3F800000 (1.0), c_ready=1 -> c_data=0x00000001 at edge N+2; GT, same operands -> 0x00000000.
- EQ, A=0x00000000, B=0x80000000 -> 1; NE, same operands -> 0; MIN, same operands -> 0x00000000 (A returned).
- MAX, A=0xC0000000 (-2.0), B=0xBF800000 (-1.0) -> 0xBF800000; MIN, same operands -> 0xC0000000.
- Back-to-back stream of 8 ops with tags 0..7; c_ready low for cycles 3-5:
  - in_ready falls after 2 buffered operations;
  - results and tags emerge 0..7 in order, with none lost;
  - outputs stay stable while stalled.
- With FPU_CMP_NAN_EN: EQ/LE with A=0x7FC00000 -> 0 and c_invalid=1; MAX with A=0x7FC00000, B=0x40000000 -> 0x40000000; without the macro, GT with the same operands -> 1.
- Assert aresetn for 1 cycle with 2 operations in flight -> c_valid=0 immediately; no stale result appears afterwards; in_ready=1 in the first cycle after release.
